// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: initiator side of the ALU operand/result interface.
// It accepts one instruction at a time over a valid/ready handshake and reads
// the operands from a small local register file. For ALU ops it drives the ALU
// for one cycle, waits for the result and writes it back, then pulses DONE.
// LDI is handled locally. Illegal opcodes and ALU timeouts pulse ERROR.
//
// Ports:
//   i_clock, i_reset     clock; asynchronous active-high reset
//   i_instr_valid        instruction fields valid
//   o_instr_ready        accepting instructions (IDLE and not in reset)
//   i_instr_op/rd/rs1/rs2/imm  instruction fields
//   o_alu_a/b/op_code    registered ALU operands and opcode
//   o_alu_enable         one-cycle issue strobe
//   i_alu_result/valid   ALU response
//   o_done, o_error      one-cycle completion / error pulses
//   i_dbg_addr/o_dbg_data  combinational register file read port
module alu_issue_ctrl #(
  parameter int unsigned DATA_SIZE      = 8,
  parameter int unsigned OP_CODE_SIZE   = 4,
  parameter int unsigned REG_ADDR_W     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_instr_valid,
  output logic                    o_instr_ready,
  input  logic [OP_CODE_SIZE-1:0] i_instr_op,
  input  logic [REG_ADDR_W-1:0]   i_instr_rd,
  input  logic [REG_ADDR_W-1:0]   i_instr_rs1,
  input  logic [REG_ADDR_W-1:0]   i_instr_rs2,
  input  logic [DATA_SIZE-1:0]    i_instr_imm,
  output logic [DATA_SIZE-1:0]    o_alu_a,
  output logic [DATA_SIZE-1:0]    o_alu_b,
  output logic [OP_CODE_SIZE-1:0] o_alu_op_code,
  output logic                    o_alu_enable,
  input  logic [DATA_SIZE-1:0]    i_alu_result,
  input  logic                    i_alu_valid,
  output logic                    o_done,
  output logic                    o_error,
  input  logic [REG_ADDR_W-1:0]   i_dbg_addr,
  output logic [DATA_SIZE-1:0]    o_dbg_data
);

  localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;
  localparam int unsigned CNT_W    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                  r_state;
  logic [DATA_SIZE-1:0]    r_regs [NUM_REGS];
  logic [REG_ADDR_W-1:0]   r_rd;
  logic [CNT_W-1:0]        r_cnt;
  logic [DATA_SIZE-1:0]    r_alu_a;
  logic [DATA_SIZE-1:0]    r_alu_b;
  logic [OP_CODE_SIZE-1:0] r_alu_op_code;
  logic                    r_alu_enable;
  logic                    r_done;
  logic                    r_error;

  logic w_accept;
  logic w_is_alu;
  logic w_is_ldi;

  // Opcode decode: 0..7 go to the ALU, 8 is LDI, everything above is illegal
  assign w_is_alu = (i_instr_op < OP_CODE_SIZE'(8));
  assign w_is_ldi = (i_instr_op == OP_CODE_SIZE'(8));
  assign w_accept = i_instr_valid & o_instr_ready;

  assign o_instr_ready = (r_state == S_IDLE) & ~i_reset;
  assign o_dbg_data    = r_regs[i_dbg_addr];

  assign o_alu_a       = r_alu_a;
  assign o_alu_b       = r_alu_b;
  assign o_alu_op_code = r_alu_op_code;
  assign o_alu_enable  = r_alu_enable;
  assign o_done        = r_done;
  assign o_error       = r_error;

  // Control FSM, register file and registered interface outputs
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_rd          <= '0;
      r_cnt         <= '0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_op_code <= '0;
      r_alu_enable  <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_alu) begin
              // Operands are captured now, so RD may alias RS1/RS2
              r_alu_a       <= r_regs[i_instr_rs1];
              r_alu_b       <= r_regs[i_instr_rs2];
              r_alu_op_code <= i_instr_op;
              r_rd          <= i_instr_rd;
              r_alu_enable  <= 1'b1;
              r_state       <= S_ISSUE;
            end else if (w_is_ldi) begin
              r_regs[i_instr_rd] <= i_instr_imm;
              r_done             <= 1'b1;
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          r_alu_enable <= 1'b0;
          r_cnt        <= '0;
          r_state      <= S_WAIT;
        end
        S_WAIT: begin
          if (i_alu_valid) begin
            r_regs[r_rd] <= i_alu_result;
            r_done       <= 1'b1;
            r_state      <= S_IDLE;
          end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // This is the TIMEOUT_CYCLES-th empty sample in WAIT
            r_error <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_alu_enable <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule
